// File: rtl/k2red_shift_pipe.sv
// Four-stage K2-RED reducer: C2 = k^2 * A mod Q for Q = k*2^m + 1, k = 2^k1 - 2^k2.
// Define K2RED_VALID_EN to add the in_valid/out_valid qualifier ports.
module k2red_shift_pipe #(
    parameter int unsigned N  = 32,
    parameter int unsigned KW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*N-1:0]   A,
    input  logic [N-1:0]     Q,
    input  logic [KW-1:0]    k1,
    input  logic [KW-1:0]    k2,
`ifdef K2RED_VALID_EN
    input  logic             in_valid,
    output logic             out_valid,
`endif
    output logic [N-1:0]     C2
);
    localparam int unsigned MW = $clog2(N + 1);
    localparam int unsigned CW = 2 * N + 2;
    localparam int unsigned PW = N + 3;

    logic [2*N-1:0]       a_s1;
    logic [N-1:0]         q_s1, q_s2, q_s3;
    logic [KW-1:0]        k1_s1, k2_s1, k1_s2, k2_s2;
    logic [MW-1:0]        m_s1, m_s2;
    logic signed [CW-1:0] c_s2;
    logic [PW-1:0]        cp_s3;

    // m = trailing zeros of Q-1
    logic [N-1:0]  q_dec;
    logic [MW-1:0] m_d;
    always_comb begin
        q_dec = Q - N'(1);
        m_d   = MW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (q_dec[i]) m_d = MW'(i);
        end
    end

    // First fold: C = k*Al - Ah
    logic [CW-1:0]        mask1, al, ah, kal;
    logic signed [CW-1:0] c_d;
    always_comb begin
        mask1 = ~({CW{1'b1}} << m_s1);
        al    = {2'b00, a_s1} & mask1;
        ah    = {2'b00, a_s1} >> m_s1;
        kal   = (al << k1_s1) - (al << k2_s1);
        c_d   = kal - ah;
    end

    // Second fold on signed C; Cl is taken as non-negative low bits
    logic [CW-1:0]        mask2, cl, kcl, cp_full;
    logic signed [CW-1:0] ch;
    logic [PW-1:0]        cp_d;
    logic                 unused_cp;
    always_comb begin
        mask2   = ~({CW{1'b1}} << m_s2);
        cl      = c_s2 & mask2;
        ch      = c_s2 >>> m_s2;
        kcl     = (cl << k1_s2) - (cl << k2_s2);
        cp_full = kcl - ch;
        cp_d    = cp_full[PW-1:0];
    end
    assign unused_cp = ^cp_full[CW-1:PW];

    // Final correction from (-Q, 2Q) into [0, Q)
    logic [PW-1:0] q_ext, corr;
    logic [N-1:0]  c2_d;
    logic          unused_corr;
    always_comb begin
        q_ext = {3'b000, q_s3};
        if (cp_s3[PW-1]) begin
            corr = cp_s3 + q_ext;
        end else if (cp_s3 >= q_ext) begin
            corr = cp_s3 - q_ext;
        end else begin
            corr = cp_s3;
        end
        c2_d = corr[N-1:0];
    end
    assign unused_corr = ^corr[PW-1:N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_s1  <= '0;
            q_s1  <= '0;
            k1_s1 <= '0;
            k2_s1 <= '0;
            m_s1  <= '0;
            c_s2  <= '0;
            q_s2  <= '0;
            k1_s2 <= '0;
            k2_s2 <= '0;
            m_s2  <= '0;
            cp_s3 <= '0;
            q_s3  <= '0;
            C2    <= '0;
        end else begin
            a_s1  <= A;
            q_s1  <= Q;
            k1_s1 <= k1;
            k2_s1 <= k2;
            m_s1  <= m_d;
            c_s2  <= c_d;
            q_s2  <= q_s1;
            k1_s2 <= k1_s1;
            k2_s2 <= k2_s1;
            m_s2  <= m_s1;
            cp_s3 <= cp_d;
            q_s3  <= q_s2;
            C2    <= c2_d;
        end
    end

`ifdef K2RED_VALID_EN
    logic [3:0] vld_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[2:0], in_valid};
        end
    end
    assign out_valid = vld_q[3];
`endif

endmodule

// File: tb/tb_k2red_shift_pipe.sv
// Scoreboard bench for k2red_shift_pipe: expectations queued at drive time, compared 4 edges later.
module tb_k2red_shift_pipe;
    localparam int unsigned N  = 32;
    localparam int unsigned KW = 6;
    localparam logic [N-1:0]   QM   = 32'd2147352577;
    localparam logic [2*N-1:0] AM   = 64'd139801577094305698;
    localparam logic [N-1:0]   CM   = 32'd81510080;
    localparam logic [N-1:0]   CK2  = 32'd268402689;
    localparam logic [N-1:0]   CNEG = 32'd2147336194;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*N-1:0] A;
    logic [N-1:0]   Q;
    logic [KW-1:0]  k1, k2;
    logic [N-1:0]   C2;
`ifdef K2RED_VALID_EN
    logic in_valid;
    logic out_valid;
`endif

    typedef struct {
        logic [N-1:0] val;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    k2red_shift_pipe #(.N(N), .KW(KW)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .Q        (Q),
        .k1       (k1),
        .k2       (k2),
`ifdef K2RED_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .C2       (C2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    // Reference: k^2 * A mod Q with wide arithmetic
    function automatic logic [N-1:0] model(input logic [2*N-1:0] a, input logic [N-1:0] q,
                                           input int h, input int l);
        logic [191:0] k, p;
        k = (192'd1 << h) - (192'd1 << l);
        p = (k * k * a) % q;
        return p[N-1:0];
    endfunction

    task automatic drive(input logic [2*N-1:0] a, input logic [N-1:0] q, input int h,
                         input int l, input logic [N-1:0] expv);
        exp_t e;
        A = a;
        Q = q;
        k1 = KW'(h);
        k2 = KW'(l);
        e.val = expv;
        e.due = cyc + 4;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        Q = QM; k1 = 6'd14; k2 = 6'd0;
        for (int i = 0; i < 5; i++) begin
            A = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (C2 !== '0) $display("FAIL reset_hold: C2=%0d expected 0", C2);
            else n_pass++;
`ifdef K2RED_VALID_EN
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
            else n_pass++;
`endif
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(AM, QM, 14, 0, CM);
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (C2 !== e.val) $display("FAIL reset_release_held: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end else begin
                if (C2 !== '0) $display("FAIL reset_release_fill: C2=%0d expected 0", C2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_vectors();
        exp_t e;
        logic [2*N-1:0] av [4];
        logic [N-1:0]   cv [4];
        av[0] = 64'd0;    cv[0] = 32'd0;
        av[1] = 64'd1;    cv[1] = CK2;
        av[2] = {32'd0, QM}; cv[2] = 32'd0;
        av[3] = AM;       cv[3] = CM;
        for (int i = 0; i < 4; i++) begin
            drive(av[i], QM, 14, 0, cv[i]);
            @(posedge clk); @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_checks++;
                if (C2 !== e.val) $display("FAIL vectors: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end
        end
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            @(posedge clk); @(negedge clk);
            if (sb[0].due == cyc) begin
                e = sb.pop_front(); n_checks++;
                if (C2 !== e.val) $display("FAIL vectors: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL vectors_drain: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_negative();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(64'd131072, QM, 14, 0, CNEG);
            @(posedge clk); @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_checks++;
                if (C2 !== e.val) $display("FAIL negative_path: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL negative_drain: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2*N-1:0] av [4];
        logic [N-1:0]   cv [4];
        av[0] = 64'd1;      cv[0] = CK2;
        av[1] = 64'd131072; cv[1] = CNEG;
        av[2] = 64'd0;      cv[2] = 32'd0;
        av[3] = AM;         cv[3] = CM;
        for (int i = 0; i < 8; i++) begin
            drive(av[i % 4], QM, 14, 0, cv[i % 4]);
            @(posedge clk); @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_checks++;
                if (C2 !== e.val) $display("FAIL stream: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end
        end
        // Mid-stream reset: in-flight results are discarded
        rst = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if (C2 !== '0) $display("FAIL stream_reset_async: C2=%0d expected 0", C2);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (C2 !== '0) $display("FAIL stream_reset_hold: C2=%0d expected 0", C2);
            else n_pass++;
        end
        rst = 1'b1;
        drive(64'd1, QM, 14, 0, CK2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (C2 !== e.val) $display("FAIL stream_restart: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end else begin
                if (C2 !== '0) $display("FAIL stream_stale: C2=%0d expected 0", C2);
                else n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL stream_drain: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Modulus and shifts change every cycle
    task automatic test_param_switch();
        exp_t e;
        logic [N-1:0]   q;
        logic [63:0]    qq;
        logic [2*N-1:0] a;
        int             h;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                if (i % 2 == 0) begin q = 32'd3221225473; h = 2; end
                else            begin q = 32'd7681;       h = 4; end
                qq = 64'(q) * 64'(q);
                a  = {$urandom, $urandom} % qq;
                drive(a, q, h, 0, model(a, q, h, 0));
            end
            @(posedge clk); @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_checks++;
                if (C2 !== e.val) $display("FAIL param_switch: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL param_switch_drain: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

`ifdef K2RED_VALID_EN
    task automatic test_valid_pulse();
        exp_t e;
        int   c0;
        logic want;
        c0 = cyc;
        in_valid = 1'b1;
        drive(AM, QM, 14, 0, CM);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            if (i < 3) drive(64'd0, QM, 14, 0, 32'd0);
            want = (cyc == c0 + 4);
            n_checks++;
            if (out_valid !== want) $display("FAIL valid_pulse: out_valid=%b expected %b", out_valid, want);
            else n_pass++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_checks++;
                if (C2 !== e.val) $display("FAIL valid_data: C2=%0d expected %0d", C2, e.val);
                else n_pass++;
            end
        end
        sb.delete();
    endtask
`endif

    initial begin
        rst = 1'b0;
        A = '0; Q = QM; k1 = 6'd14; k2 = 6'd0;
`ifdef K2RED_VALID_EN
        in_valid = 1'b0;
`endif
        test_reset();
        test_vectors();
        test_negative();
        test_back_to_back();
        test_param_switch();
`ifdef K2RED_VALID_EN
        test_valid_pulse();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
